mult_share_sched: RTL and testbench

Round-robin scheduler that time-shares one registered signed Q1.6 constant-multiply datapath (8-bit input × 8-bit coefficient, 8-bit output taken from product bits [13:6]) among four requesters. Each requester has its own programmable coefficient, default 21/64 (≈1/3). The block sits between the sample producers and the downstream consumer. It issues at most one operation per cycle and returns each result tagged with its requester index. A valid/ready handshake on the result port provides backpressure.

---
 rtl/mult_share_sched.sv | 105 ++++++++++
 tb/tb_mult_share_sched.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one registered signed Q1.6 constant multiplier
// among four requesters; results are tagged with the owner and held under backpressure.
module mult_share_sched #(
  parameter int               NREQ     = 4,
  parameter logic signed [7:0] COEF_RST = 8'sb00_010101
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     ack,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic signed [7:0]   cfg_coef,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_tag,
  output logic [7:0]          out_data
);

  logic signed [7:0]  coef [NREQ];
  logic [1:0]         ptr;
  logic               adv;
  logic               found;
  logic [1:0]         grant_idx;
  logic [1:0]         idx;

  logic               s1_valid;
  logic signed [7:0]  s1_op;
  logic signed [7:0]  s1_coef;
  logic [1:0]         s1_tag;
  logic signed [15:0] prod;
  logic               unused_prod;

  assign adv = !(out_valid && !out_ready);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (adv && found) ack[grant_idx] = 1'b1;
  end

  // NOTE: the coefficient bank is a handful of flops with a defined power-up
  // value, so it is reset like any other state rather than left as a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) coef[i] <= COEF_RST;
    end else if (cfg_we) begin
      coef[cfg_sel] <= cfg_coef;
    end
  end

  // NOTE: non-blocking assignments make a same-cycle coefficient write invisible
  // to the grant sampling it; the operation uses the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_coef  <= '0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_valid <= found;
      if (found) begin
        ptr     <= grant_idx + 2'd1;
        s1_op   <= req_data[{grant_idx, 3'b000} +: 8];
        s1_coef <= coef[grant_idx];
        s1_tag  <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      prod      <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        prod    <= s1_op * s1_coef;
        out_tag <= s1_tag;
      end
    end
  end

  // Q1.6 x Q1.6 -> keep bits [13:6]: floor truncation, wraps on overflow.
  assign out_data    = prod[13:6];
  assign unused_prod = ^{prod[15:14], prod[5:0]};

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched with hand-computed results.
module tb_mult_share_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_coef;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_tag;
  logic [7:0]  out_data;

  int checks   = 0;
  int failures = 0;

  mult_share_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_coef (cfg_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tag  (out_tag),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single isolated operation on requester idx; result checked 2 cycles after the ack cycle.
  task automatic run_one(input int idx, input logic [7:0] op, input logic [7:0] exp, input string name);
    req                  = 4'(1 << idx);
    req_data             = '0;
    req_data[8*idx +: 8] = op;
    #1;
    check({name, "_ack"}, {4'b0, ack}, 8'(1 << idx));
    tick();
    req = '0;
    #1;
    check({name, "_bubble"}, {7'b0, out_valid}, 8'd0);
    tick();
    check({name, "_valid"}, {7'b0, out_valid}, 8'd1);
    check({name, "_tag"},   {6'b0, out_tag},   8'(idx));
    check({name, "_data"},  out_data,          exp);
    tick();
    check({name, "_drain"}, {7'b0, out_valid}, 8'd0);
  endtask

  logic [7:0] rr_exp [4];

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_coef  = '0;
    out_ready = 1'b1;
    #23;
    rst_n = 1'b1;
    tick();

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      check("idle_valid", {7'b0, out_valid}, 8'd0);
      check("idle_data",  out_data,          8'd0);
      check("idle_ack",   {4'b0, ack},       8'd0);
      tick();
    end

    // Default coefficient 21: 96*21=2016 -> 31; -96*21=-2016 -> -32.
    run_one(2, 8'd96, 8'd31, "rd_coef2");
    run_one(0, 8'(-96), 8'(-32), "neg_trunc");

    // -128 * -128 = 16384 -> bits [13:6] wrap to 0.
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_coef = 8'h80;
    tick();
    cfg_we = 1'b0;
    run_one(3, 8'h80, 8'd0, "wrap");

    // Same-cycle write of 1.0 to entry 1 with a grant to 1: old coefficient used.
    req = 4'b0010; req_data = '0; req_data[15:8] = 8'd60;
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_coef = 8'd64;
    #1;
    check("race_ack", {4'b0, ack}, 8'h02);
    tick();
    req = '0; cfg_we = 1'b0;
    tick();
    check("race_valid", {7'b0, out_valid}, 8'd1);
    check("race_data",  out_data,          8'd19);
    tick();
    run_one(1, 8'd60, 8'd60, "new_coef");

    // Reset one cycle after a grant discards the operation.
    req = 4'b1000; req_data = '0; req_data[31:24] = 8'd50;
    #1;
    check("rst_ack", {4'b0, ack}, 8'h08);
    tick();
    req   = '0;
    rst_n = 1'b0;
    #1;
    check("rst_valid_low", {7'b0, out_valid}, 8'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_no_result", {7'b0, out_valid}, 8'd0);
      tick();
    end

    // Round-robin with a 5-cycle stall in the middle. Coefficients are back to 21.
    // 10*21/64=3, 20*21/64=6, 30*21/64=9, 40*21/64=13.
    rr_exp[0] = 8'd3; rr_exp[1] = 8'd6; rr_exp[2] = 8'd9; rr_exp[3] = 8'd13;
    req      = 4'b1111;
    req_data = {8'd40, 8'd30, 8'd20, 8'd10};
    begin
      int g = 0;
      int r = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        logic stall;
        stall     = (cyc >= 8) && (cyc < 13);
        out_ready = !stall;
        #1;
        if (stall) begin
          check("stall_ack",   {4'b0, ack},       8'd0);
          check("stall_valid", {7'b0, out_valid}, 8'd1);
          check("stall_tag",   {6'b0, out_tag},   8'(r % 4));
          check("stall_data",  out_data,          rr_exp[r % 4]);
        end else begin
          check("rr_ack", {4'b0, ack}, 8'(1 << (g % 4)));
          g++;
          if (cyc >= 2) begin
            check("rr_valid", {7'b0, out_valid}, 8'd1);
            check("rr_tag",   {6'b0, out_tag},   8'(r % 4));
            check("rr_data",  out_data,          rr_exp[r % 4]);
            r++;
          end
        end
        @(posedge clk);
        #1;
      end
    end
    req       = '0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("final_idle", {7'b0, out_valid}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
